// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity encodings,
// receiver state type and the baud divider calculation.
package uart_pkg;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_hz + den / 32'sd2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling baud generator: a clock divider producing one tick every DIV
// clocks and a tick counter that numbers the ticks 0..OS-1 within a bit.
// Restarting realigns both counters to the start edge of a frame.
module uart_baud_tick #(
  parameter int DIV = 27,
  parameter int OS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  output logic                  tick,
  output logic [$clog2(OS)-1:0] tick_cnt,
  output logic                  bit_end
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(OS);

  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;

  assign tick     = (div_q == DIV_W'(DIV - 1));
  assign tick_cnt = cnt_q;
  assign bit_end  = tick && (cnt_q == CNT_W'(OS - 1));

  // Divider and in-bit tick counter, both cleared on restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (restart) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (tick) begin
      div_q <= '0;
      cnt_q <= (cnt_q == CNT_W'(OS - 1)) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, edge detect, 3-sample majority
// vote around mid-bit, configurable data/parity/stop framing, error flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_rx_en,
  input  logic                 I_rs232_rxd,
  output logic [DATA_BITS-1:0] O_data,
  output logic                 O_valid,
  output logic                 O_parity_err,
  output logic                 O_frame_err,
  output logic                 O_busy
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] T_S0 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] T_S1 = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] T_V  = CNT_W'(OVERSAMPLE / 2 + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
  end

  // Expected parity bit for a completed data word.
  function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
    if (PARITY == PAR_ODD) return ~^d;
    else                   return ^d;
  endfunction

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [2:0]           hist_q;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic [BC_W-1:0]      bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 perr_acc_q, ferr_acc_q;
  logic                 valid_q, perr_q, ferr_q, busy_q;

  logic                 tick_s, bit_end_s;
  logic [CNT_W-1:0]     tick_cnt_s;
  logic                 line_s, fall_s, start_s, vote_tick_s, vote_s, last_stop_s;
  logic                 shift_en_s, par_chk_s, stop_vote_s, stop_adv_s, load_s;

  // Line is the newest history bit; an edge needs two highs followed by a low.
  assign line_s      = hist_q[0];
  assign fall_s      = hist_q[2] & hist_q[1] & ~hist_q[0];
  assign start_s     = (state_q == ST_IDLE) && fall_s && I_rx_en;
  assign vote_tick_s = tick_s && (tick_cnt_s == T_V);
  assign vote_s      = (smp_q[0] & smp_q[1]) | (smp_q[0] & line_s) | (smp_q[1] & line_s);
  assign last_stop_s = (stop_cnt_q == 1'(STOP_BITS - 1));

  uart_baud_tick #(
    .DIV (DIV),
    .OS  (OVERSAMPLE)
  ) u_tick (
    .clk      (I_clk),
    .rst      (I_rst),
    .restart  (start_s),
    .tick     (tick_s),
    .tick_cnt (tick_cnt_s),
    .bit_end  (bit_end_s)
  );

  // Input synchroniser and edge/vote history, idle-high after reset.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= I_rs232_rxd;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[1:0], sync2_q};
    end
  end

  // FSM state register.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a dropped enable aborts any frame.
  always_comb begin
    state_d = state_q;
    if (!I_rx_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (fall_s) state_d = ST_START; else state_d = ST_IDLE;
        ST_START: begin
          if (vote_tick_s && vote_s) state_d = ST_IDLE;
          else if (bit_end_s)        state_d = ST_DATA;
          else                       state_d = ST_START;
        end
        ST_DATA: begin
          if (bit_end_s && (bit_cnt_q == BC_W'(DATA_BITS)))
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else
            state_d = ST_DATA;
        end
        ST_PARITY: if (bit_end_s) state_d = ST_STOP; else state_d = ST_PARITY;
        ST_STOP:   if (vote_tick_s && last_stop_s) state_d = ST_DONE; else state_d = ST_STOP;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM datapath controls derived from the current state.
  always_comb begin
    shift_en_s  = 1'b0;
    par_chk_s   = 1'b0;
    stop_vote_s = 1'b0;
    stop_adv_s  = 1'b0;
    load_s      = 1'b0;
    if (I_rx_en) begin
      case (state_q)
        ST_DATA:   shift_en_s = vote_tick_s;
        ST_PARITY: par_chk_s  = vote_tick_s;
        ST_STOP: begin
          stop_vote_s = vote_tick_s;
          stop_adv_s  = bit_end_s;
          load_s      = vote_tick_s && last_stop_s;
        end
        default:   shift_en_s = 1'b0;
      endcase
    end else begin
      shift_en_s = 1'b0;
    end
  end

  // Sampling, frame accumulation and registered outputs.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      smp_q      <= 2'b11;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (tick_s && (tick_cnt_s == T_S0)) smp_q[0] <= line_s;
      if (tick_s && (tick_cnt_s == T_S1)) smp_q[1] <= line_s;
      if (start_s) begin
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        perr_acc_q <= 1'b0;
        ferr_acc_q <= 1'b0;
      end else begin
        if (shift_en_s) begin
          shift_q   <= {vote_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_q <= bit_cnt_q + BC_W'(1);
        end
        if (par_chk_s)   perr_acc_q <= (vote_s != exp_parity(shift_q));
        if (stop_vote_s) ferr_acc_q <= ferr_acc_q | ~vote_s;
        if (stop_adv_s)  stop_cnt_q <= stop_cnt_q + 1'b1;
      end
      valid_q <= load_s;
      if (load_s) begin
        data_q <= shift_q;
        perr_q <= perr_acc_q;
        ferr_q <= ferr_acc_q | ~vote_s;
      end
      busy_q <= (state_d != ST_IDLE);
    end
  end

  assign O_data       = data_q;
  assign O_valid      = valid_q;
  assign O_parity_err = perr_q;
  assign O_frame_err  = ferr_q;
  assign O_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1 @115200, 7E1 and 8O2 at
// 460800), a frame-level reference model with an expectation queue, and one
// per-cycle compare process checking O_valid frames and held outputs.
module tb_uart_rx_param;

  logic       clk, rst;
  logic [2:0] rxd, en;
  wire  [2:0] vld, pe, fe, bsy;
  wire  [7:0] d0, d2;
  wire  [6:0] d1;
  logic [8:0] dat [3];

  int db_a  [3] = '{8, 7, 8};
  int par_a [3] = '{0, 2, 1};
  int nst_a [3] = '{1, 1, 2};
  int blen_a[3];

  typedef struct { int idx; logic [8:0] data; bit pe; bit fe; int exp; } exp_t;
  exp_t q[$];

  int total = 0, bad = 0, cyc = 0;
  int vcount[3] = '{0, 0, 0};
  logic [8:0] held_d[3] = '{9'd0, 9'd0, 9'd0};
  bit held_p[3] = '{1'b0, 1'b0, 1'b0};
  bit held_f[3] = '{1'b0, 1'b0, 1'b0};
  bit checking = 1'b0;

  uart_rx_param #(.CLK_HZ(50_000_000), .BAUD(115200), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .I_clk(clk), .I_rst(rst), .I_rx_en(en[0]), .I_rs232_rxd(rxd[0]),
    .O_data(d0), .O_valid(vld[0]), .O_parity_err(pe[0]), .O_frame_err(fe[0]), .O_busy(bsy[0]));
  uart_rx_param #(.CLK_HZ(50_000_000), .BAUD(460800), .OVERSAMPLE(16),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .I_clk(clk), .I_rst(rst), .I_rx_en(en[1]), .I_rs232_rxd(rxd[1]),
    .O_data(d1), .O_valid(vld[1]), .O_parity_err(pe[1]), .O_frame_err(fe[1]), .O_busy(bsy[1]));
  uart_rx_param #(.CLK_HZ(50_000_000), .BAUD(460800), .OVERSAMPLE(8),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u2 (
    .I_clk(clk), .I_rst(rst), .I_rx_en(en[2]), .I_rs232_rxd(rxd[2]),
    .O_data(d2), .O_valid(vld[2]), .O_parity_err(pe[2]), .O_frame_err(fe[2]), .O_busy(bsy[2]));

  always_comb begin
    dat[0] = {1'b0, d0};
    dat[1] = {2'b00, d1};
    dat[2] = {1'b0, d2};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut=%0d actual=%0h required=%0h cyc=%0d", nm, idx, act, exp, cyc);
    end
  endtask

  // Clocks per bit from the line rate: oversample times the rounded divider.
  function automatic int bit_len(input int clk_hz, input int baud, input int os);
    return os * ((clk_hz + (baud * os) / 2) / (baud * os));
  endfunction

  // Parity bit a correct transmitter appends: total ones odd (1) or even (2).
  function automatic bit good_par(input logic [8:0] d, input int db, input int mode);
    int ones;
    ones = $countones(int'(d) & ((1 << db) - 1));
    if (mode == 1) return (ones % 2) == 0;
    else           return (ones % 2) == 1;
  endfunction

  task automatic send_bits(input int idx, input logic [15:0] bits, input int n,
                           input int blen, input int gb);
    for (int b = 0; b < n; b++)
      for (int c = 0; c < blen; c++) begin
        @(negedge clk);
        rxd[idx] = ((b == gb) && (c == blen / 2)) ? ~bits[b] : bits[b];
      end
  endtask

  // Build a frame, record what the receiver must report, send up to maxb bits.
  task automatic tx_frame(input int idx, input logic [8:0] data, input bit par_bit,
                          input logic [1:0] stop_v, input int blen, input int gb,
                          input bit expect_it, input int maxb);
    logic [15:0] bits;
    int n;
    exp_t e;
    bits = 16'hFFFF;
    bits[0] = 1'b0;
    for (int i = 0; i < db_a[idx]; i++) bits[1 + i] = data[i];
    n = 1 + db_a[idx];
    if (par_a[idx] != 0) begin bits[n] = par_bit; n++; end
    e.fe = 1'b0;
    for (int s = 0; s < nst_a[idx]; s++) begin
      bits[n] = stop_v[s];
      n++;
      if (!stop_v[s]) e.fe = 1'b1;
    end
    e.idx  = idx;
    e.data = data & 9'((1 << db_a[idx]) - 1);
    e.pe   = (par_a[idx] != 0) && (par_bit != good_par(data, db_a[idx], par_a[idx]));
    e.exp  = cyc + 1 + (n - 1) * blen + blen / 2;
    if (expect_it) q.push_back(e);
    send_bits(idx, bits, (maxb < n) ? maxb : n, blen, gb);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    chk("drain", 0, q.size(), 0);
  endtask

  // Per-cycle comparison of every receiver against the model.
  always @(negedge clk) begin
    exp_t e;
    int lt;
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        if (vld[i]) begin
          vcount[i]++;
          if (q.size() == 0 || q[0].idx != i) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid dut=%0d actual data=%0h required no pulse", i, dat[i]);
            held_d[i] = dat[i];
            held_p[i] = pe[i];
            held_f[i] = fe[i];
          end else begin
            e = q.pop_front();
            lt = cyc - e.exp;
            chk("frame_data", i, int'(dat[i]), int'(e.data));
            chk("frame_perr", i, int'(pe[i]), int'(e.pe));
            chk("frame_ferr", i, int'(fe[i]), int'(e.fe));
            chk("frame_latency_ok", i, (lt >= 0 && lt <= blen_a[i] / 2 + 40) ? 1 : 0, 1);
            held_d[i] = e.data;
            held_p[i] = e.pe;
            held_f[i] = e.fe;
          end
        end else begin
          chk("hold_data", i, int'(dat[i]), int'(held_d[i]));
          chk("hold_perr", i, int'(pe[i]), int'(held_p[i]));
          chk("hold_ferr", i, int'(fe[i]), int'(held_f[i]));
        end
      end
      if (q.size() != 0 && cyc > q[0].exp + blen_a[q[0].idx]) begin
        total++;
        bad++;
        $display("FAIL missing_valid dut=%0d actual none required data=%0h", q[0].idx, q[0].data);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic [8:0] rd;
    int idx;
    blen_a[0] = bit_len(50_000_000, 115200, 16);
    blen_a[1] = bit_len(50_000_000, 460800, 16);
    blen_a[2] = bit_len(50_000_000, 460800, 8);
    rxd = 3'b111;
    en  = 3'b111;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_valid", i, int'(vld[i]), 0);
      chk("reset_busy", i, int'(bsy[i]), 0);
      chk("reset_data", i, int'(dat[i]), 0);
      chk("reset_perr", i, int'(pe[i]), 0);
      chk("reset_ferr", i, int'(fe[i]), 0);
    end
    checking = 1'b1;
    repeat (50) @(negedge clk);

    // 8N1 byte 0xA5.
    tx_frame(0, 9'h0A5, 1'b0, 2'b11, blen_a[0], -1, 1'b1, 99);
    wait_drain(20000);
    chk("t1_data_lit", 0, int'(dat[0]), 32'h0A5);
    chk("t1_err_lit", 0, int'({pe[0], fe[0]}), 0);

    // 7E1 0x41 with parity bit forced to 1.
    tx_frame(1, 9'h041, 1'b1, 2'b11, blen_a[1], -1, 1'b1, 99);
    wait_drain(20000);
    chk("t2_data_lit", 1, int'(dat[1]), 32'h041);
    chk("t2_perr_lit", 1, int'(pe[1]), 1);

    // 8O2 with the second stop bit low: one pulse, frame error.
    v0 = vcount[2];
    tx_frame(2, 9'h05A, 1'b1, 2'b01, blen_a[2], -1, 1'b1, 99);
    rxd[2] = 1'b1;
    wait_drain(20000);
    repeat (3 * blen_a[2]) @(negedge clk);
    chk("t3_one_valid", 2, vcount[2] - v0, 1);
    chk("t3_ferr_lit", 2, int'(fe[2]), 1);
    chk("t3_perr_lit", 2, int'(pe[2]), 0);

    // 200-clock glitch on idle line, then 0x3C.
    rxd[0] = 1'b0;
    repeat (100) @(negedge clk);
    chk("t4_busy_glitch", 0, int'(bsy[0]), 1);
    repeat (100) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (150) @(negedge clk);
    chk("t4_busy_rejected", 0, int'(bsy[0]), 0);
    repeat (blen_a[0]) @(negedge clk);
    tx_frame(0, 9'h03C, 1'b0, 2'b11, blen_a[0], -1, 1'b1, 99);
    wait_drain(20000);
    chk("t4_data_lit", 0, int'(dat[0]), 32'h03C);

    // Enable dropped during data bit 4.
    tx_frame(0, 9'h096, 1'b0, 2'b11, blen_a[0], -1, 1'b0, 5);
    repeat (200) @(negedge clk);
    chk("t5_busy_before", 0, int'(bsy[0]), 1);
    en[0] = 1'b0;
    @(negedge clk);
    chk("t5_busy_after", 0, int'(bsy[0]), 0);
    rxd[0] = 1'b1;
    repeat (2 * blen_a[0]) @(negedge clk);
    en[0] = 1'b1;
    repeat (blen_a[0]) @(negedge clk);
    chk("t5_data_kept", 0, int'(dat[0]), 32'h03C);

    // Back-to-back 0x00, 0xFF about 2% fast with a one-clock mid-bit glitch.
    tx_frame(0, 9'h000, 1'b0, 2'b11, 423, 3, 1'b1, 99);
    tx_frame(0, 9'h0FF, 1'b0, 2'b11, 423, 3, 1'b1, 99);
    rxd[0] = 1'b1;
    wait_drain(20000);
    chk("t6_data_lit", 0, int'(dat[0]), 32'h0FF);

    // Break on the 7E1 line: exactly one frame-error frame.
    v0 = vcount[1];
    tx_frame(1, 9'h000, 1'b0, 2'b00, blen_a[1], -1, 1'b1, 99);
    repeat (20 * blen_a[1]) @(negedge clk);
    rxd[1] = 1'b1;
    repeat (2 * blen_a[1]) @(negedge clk);
    wait_drain(20000);
    chk("t7_one_valid", 1, vcount[1] - v0, 1);
    chk("t7_ferr_lit", 1, int'(fe[1]), 1);

    // Randomised frames on all three receivers.
    for (int k = 0; k < 14; k++) begin
      idx = (k % 4 == 0) ? 0 : int'($urandom_range(1, 2));
      rd  = 9'($urandom_range(0, 511));
      tx_frame(idx, rd,
               good_par(rd, db_a[idx], par_a[idx]) ^ ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11,
               blen_a[idx], -1, 1'b1, 99);
      rxd[idx] = 1'b1;
      wait_drain(20000);
      repeat (blen_a[idx] * int'($urandom_range(1, 3))) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("final_queue_empty", 0, q.size(), 0);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
